calc_seq_ctrl: RTL and testbench
================================

// Module: calc_seq_ctrl
//
// PURPOSE
//  Sequencing controller for the switch calculator. Captures operands/opcode on a start pulse.
//  Executes add/sub/mul in one cycle and divide as a multi-cycle restoring loop.
//  Presents a registered result with a done pulse.
//  Sits between the debounced button/switch front end and the 7-segment display formatter.
//
// PARAMETERS
//  W   4   operand width in bits; result width is 2*W
//
// PORTS
//  clk     in   1     system clock, all logic on rising edge
//  rst     in   1     synchronous, active-high reset
//  start   in   1     request; sampled only when busy=0
//  a       in   W     first operand (unsigned)
//  b       in   W     second operand (unsigned)
//  op      in   2     00 add, 01 sub, 10 mul, 11 div
//  busy    out  1     high in every state except IDLE
//  done    out  1     one-cycle pulse, result valid from this cycle
//  result  out  2*W   registered result, held until next done
//  err     out  1     divide-by-zero flag, valid with done (see CONFIGURATION)
//
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, result=0, err=0. Applies mid-operation:
//    - abandons any divide; no done is issued for it.
//  - FSM states:
//    - IDLE -> EXEC on start=1: latch a, b, op into internal regs.
//    - EXEC, op!=11: compute, register result -> DONE.
//    - EXEC, op=11, b_q=0: -> DONE with the divide-by-zero result.
//    - EXEC, op=11, b_q!=0: init divider (rem=0, quo=a_q), cnt=W-1 -> DIV.
//    - DIV: one restoring step per cycle; cnt==0 on a step -> DONE.
//    - DONE: done=1 for exactly one cycle -> IDLE.
//  - Latency (start sampled at edge k): done high in the cycle after edge k+2.
//    - Divide with b!=0: done high in the cycle after edge k+2+W.
//  - start while busy=1 is ignored, not queued. Inputs a, b, op may change freely after the start edge.
//  - start in the DONE cycle is ignored; earliest accepted restart is the cycle after done.
//  - Arithmetic, zero-extended to 2*W:
//    - add: W+1-bit sum.
//    - sub: (a-b) mod 2^W; high W bits zero.
//    - mul: full 2*W product.
//    - div: {remainder[W-1:0], quotient[W-1:0]}.
//  - Divide step: rem' = {rem,quo[W-1]}; if rem' >= b_q: rem' -= b_q, quo bit=1.
//    - Width rules: rem held W+1 bits internally; output truncated to W.
//  - result/err update only at the DONE transition; otherwise held.
//
// CONFIGURATION
//  CALC_DIV0_ERR_EN defined:
//   - divide by zero gives result = all ones, err=1 during done.
//   - err cleared at the next DONE.
//  CALC_DIV0_ERR_EN undefined:
//   - divide by zero gives result = 0.
//   - err tied to 0.
//  Latency for divide by zero is 2 in both builds.
//
// STRUCTURE
//  calc_pkg:
//   - opcode localparams OP_ADD/OP_SUB/OP_MUL/OP_DIV.
//   - state encodings S_IDLE/S_EXEC/S_DIV/S_DONE.
//  Sub-module calc_div_step: combinational single restoring step.
//   - in: rem, quo, divisor. out: next rem, next quo.
//   - instantiated once, iterated by the FSM.
//
// TESTING (W=4)
//  - add a=9 b=7, start at edge k -> done after edge k+2, result=8'h10, err=0.
//  - sub a=3 b=5 -> result=8'h0E; mul a=15 b=15 -> result=8'hE1, done after edge k+2.
//  - div a=13 b=4 -> result=8'h13 (rem 1, quo 3).
//    - done after edge k+6; busy high for exactly 6 cycles.
//  - div a=9 b=0 -> done after edge k+2.
//    - with CALC_DIV0_ERR_EN: result=8'hFF, err=1.
//    - without: result=8'h00, err=0.
//  - div 13/4 in flight, start pulsed with add 1+1 at k+3 -> ignored.
//    - single done, result=8'h13.
//  - rst asserted at k+3 of a divide -> next cycle busy=0, result=0, no done.
//    - a fresh add 2+2 then completes with result=8'h04.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// =============================================================================
// Module      : calc_pkg
// Description : Opcode and FSM state encodings for the calculator sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_EXEC = 2'd1;
    localparam logic [STATE_W-1:0] S_DIV  = 2'd2;
    localparam logic [STATE_W-1:0] S_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/calc_seq_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module      : calc_seq_ctrl_if
// Description : Request/response bundle between the front end and the sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
interface calc_seq_ctrl_if #(
    parameter int W = 4
);
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             err;

    modport master (
        output start, a, b, op,
        input  busy, done, result, err
    );

    modport slave (
        input  start, a, b, op,
        output busy, done, result, err
    );
endinterface
`default_nettype wire

// File: rtl/calc_div_step.sv
`default_nettype none
// =============================================================================
// Module      : calc_div_step
// Description : One combinational restoring-division step (shift, compare, subtract).
// Revision    : 1.0 - initial release
// =============================================================================
module calc_div_step #(
    parameter int W = 4
) (
    input  wire logic [W:0]   i_rem,
    input  wire logic [W-1:0] i_quo,
    input  wire logic [W-1:0] i_divisor,
    output logic      [W:0]   o_rem,
    output logic      [W-1:0] o_quo
);

    logic [W:0] shifted_w;
    logic       ge_w;

    // i_rem[W] would shift out of the W+1-bit window; if set, the true
    // partial remainder already exceeds any W-bit divisor.
    always_comb begin
        shifted_w = {i_rem[W-1:0], i_quo[W-1]};
        ge_w      = i_rem[W] | (shifted_w >= {1'b0, i_divisor});
        o_rem     = ge_w ? (shifted_w - {1'b0, i_divisor}) : shifted_w;
        o_quo     = {i_quo[W-2:0], ge_w};
    end

endmodule
`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : calc_seq_ctrl
// Description : Calculator sequencer: 1-cycle add/sub/mul, iterative restoring
//               divide, registered result with done pulse. Optional macro
//               CALC_DIV0_ERR_EN flags divide-by-zero (all-ones result, err=1).
// Revision    : 1.0 - initial release
// =============================================================================
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    calc_seq_ctrl_if.slave bus
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
`ifdef CALC_DIV0_ERR_EN
    localparam logic [2*W-1:0] DIV0_RES = {(2*W){1'b1}};
`else
    localparam logic [2*W-1:0] DIV0_RES = '0;
`endif

    logic [STATE_W-1:0] state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [W:0]         rem_q, rem_d;
    logic [W-1:0]       quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*W-1:0]     res_q, res_d;
    logic [2*W-1:0]     result_q, result_d;
    logic               done_q, done_d;
`ifdef CALC_DIV0_ERR_EN
    logic               div0_q, div0_d;
    logic               err_q, err_d;
`endif

    logic [W:0]         step_rem_w;
    logic [W-1:0]       step_quo_w;
    logic [W-1:0]       diff_w;
    logic               busy_w;

    calc_div_step #(.W(W)) u_div_step (
        .i_rem     (rem_q),
        .i_quo     (quo_q),
        .i_divisor (b_q),
        .o_rem     (step_rem_w),
        .o_quo     (step_quo_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef CALC_DIV0_ERR_EN
            div0_q   <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef CALC_DIV0_ERR_EN
            div0_q   <= div0_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef CALC_DIV0_ERR_EN
        div0_d   = div0_q;
        err_d    = err_q;
`endif
        diff_w   = a_q - b_q;

        case (state_q)
            S_IDLE: begin
                // The done cycle is still IDLE, but a restart there is refused.
                if (bus.start && !done_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef CALC_DIV0_ERR_EN
                div0_d  = 1'b0;
`endif
                state_d = S_DONE;
                case (op_q)
                    OP_ADD:  res_d = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
                    OP_SUB:  res_d = {{W{1'b0}}, diff_w};
                    OP_MUL:  res_d = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
                    default: begin
                        if (b_q == '0) begin
                            res_d  = DIV0_RES;
`ifdef CALC_DIV0_ERR_EN
                            div0_d = 1'b1;
`endif
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_q;
                            cnt_d   = CW'(W - 1);
                            state_d = S_DIV;
                        end
                    end
                endcase
            end
            S_DIV: begin
                rem_d = step_rem_w;
                quo_d = step_quo_w;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    res_d   = {step_rem_w[W-1:0], step_quo_w};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d = res_q;
                done_d   = 1'b1;
`ifdef CALC_DIV0_ERR_EN
                err_d    = div0_q;
`endif
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_w = (state_q != S_IDLE);
    end

    assign bus.busy   = busy_w;
    assign bus.done   = done_q;
    assign bus.result = result_q;
`ifdef CALC_DIV0_ERR_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_calc_seq_ctrl
// Description : Scoreboard bench for calc_seq_ctrl (W=4); honours CALC_DIV0_ERR_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_calc_seq_ctrl;

    localparam int W = 4;
`ifdef CALC_DIV0_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_seq_ctrl_if #(.W(W)) bus ();

    calc_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] res;
        logic           err;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int free_edge = 0;
    int win_k = 0;
    int win_end = 0;
    int rst_edge = -1;
    logic [2*W-1:0] last_res = '0;
    logic           last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation's definition.
    function automatic exp_t model(input int a, input int b, input int op, input int k);
        exp_t e;
        int lat;
        lat = 2;
        e.err = 1'b0;
        case (op)
            0: e.res = (2*W)'(a + b);
            1: e.res = (2*W)'((a - b) & ((1 << W) - 1));
            2: e.res = (2*W)'(a * b);
            default: begin
                if (b == 0) begin
                    e.res = ERR_EN ? {(2*W){1'b1}} : '0;
                    e.err = ERR_EN;
                end else begin
                    e.res = (2*W)'((a % b) * (1 << W) + (a / b));
                    lat   = 2 + W;
                end
            end
        endcase
        e.cyc = k + lat;
        return e;
    endfunction

    always @(negedge clk) begin
        if (cyc == rst_edge) begin
            sb.delete();
            last_res = '0;
            last_err = 1'b0;
            win_end  = 0;
        end
        if (cyc >= 2) begin
            check("busy", 32'(bus.busy), 32'(cyc >= win_k && cyc < win_end));
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done cyc=%0d got=1 want=0", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("result", 32'(bus.result), 32'(mon_e.res));
                    check("err", 32'(bus.err), 32'(mon_e.err));
                    last_res = mon_e.res;
                    last_err = mon_e.err;
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_done cyc=%0d got=%0b want=1", cyc, bus.done);
                    void'(sb.pop_front());
                end
                check("result_hold", 32'(bus.result), 32'(last_res));
                check("err_hold", 32'(bus.err), 32'(last_err));
            end
        end
    end

    task automatic drive(input bit s, input int a, input int b, input int op);
        exp_t e;
        @(negedge clk);
        bus.start = s;
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.op    = 2'(op);
        if (s && (cyc + 1) >= free_edge) begin
            e = model(a, b, op, cyc + 1);
            sb.push_back(e);
            win_k     = cyc + 1;
            win_end   = e.cyc;
            free_edge = e.cyc + 2;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
    endtask

    task automatic wait_free();
        int guard = 0;
        while ((cyc + 1) < free_edge && guard < 100) begin
            idle(1);
            guard++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b1;
        rst_edge  = cyc + 1;
        free_edge = cyc + 2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 9, 7, 0);   wait_free();
        drive(1'b1, 3, 5, 1);   wait_free();
        drive(1'b1, 15, 15, 2); wait_free();
        drive(1'b1, 13, 4, 3);  wait_free();
        drive(1'b1, 9, 0, 3);   wait_free();

        // Start pulse mid-divide must be dropped.
        drive(1'b1, 13, 4, 3);
        idle(2);
        drive(1'b1, 1, 1, 0);
        wait_free();

        // Reset three edges into a divide, then a fresh add.
        drive(1'b1, 13, 4, 3);
        idle(2);
        do_reset();
        drive(1'b1, 2, 2, 0);
        wait_free();

        repeat (400) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 15),
                  ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15),
                  $urandom_range(0, 3));
        end
        wait_free();
        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
